// File: rtl/aggr_pkg.sv
// aggr_pkg: shared types, widths and helpers for the GAT aggregator.
//   - aggr_state_e : aggregator FSM states
//   - WOF          : fractional bits of the Q1.31 alpha
//   - PROD_W/ACC_W : product and accumulator widths of one MAC lane
//   - saturate()   : arithmetic shift by WOF and clamp to NEW_FEATURE_WIDTH
package aggr_pkg;

    localparam int WH_DATA_WIDTH     = 12;
    localparam int ALPHA_DATA_WIDTH  = 32;
    localparam int NEW_FEATURE_WIDTH = 32;
    localparam int NUM_FEATURE_OUT   = 16;
    localparam int MAX_NODES         = 168;
    localparam int NUM_NODE_WIDTH    = $clog2(MAX_NODES);
    localparam int FEAT_IDX_W        = $clog2(NUM_FEATURE_OUT);
    localparam int WOF               = 31;

    // alpha is zero-extended by one bit so it multiplies as a positive signed value
    localparam int PROD_W   = WH_DATA_WIDTH + ALPHA_DATA_WIDTH + 1;
    localparam int ACC_W    = PROD_W + NUM_NODE_WIDTH;
    localparam int WH_ROW_W = WH_DATA_WIDTH * NUM_FEATURE_OUT + NUM_NODE_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4
    } aggr_state_e;

    // Drop the WOF fractional bits, then clamp into the signed output range.
    // In range when every bit from the output sign bit upwards agrees.
    function automatic logic [NEW_FEATURE_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0]            shifted;
        logic [ACC_W-NEW_FEATURE_WIDTH:0]   hi;
        shifted = acc >>> WOF;
        hi      = shifted[ACC_W-1:NEW_FEATURE_WIDTH-1];
        if ((&hi) || !(|hi))
            saturate = shifted[NEW_FEATURE_WIDTH-1:0];
        else if (hi[ACC_W-NEW_FEATURE_WIDTH])
            saturate = {1'b1, {(NEW_FEATURE_WIDTH-1){1'b0}}};
        else
            saturate = {1'b0, {(NEW_FEATURE_WIDTH-1){1'b1}}};
    endfunction

endpackage

// File: rtl/aggr_if.sv
// aggr_if: bundle of every aggregator-facing signal except clk/rst_n.
//   slave  modport : aggregator side
//   master modport : environment side (softmax FIFO, BRAMs, controller)
// Handshakes:
//   - aggr_vld_i is a level enable; aggr_rdy_o pulses for one cycle with the
//     final feature write of each subgraph.
//   - alpha FIFO is first-word-fall-through: alpha_ff_dout is the head while
//     alpha_ff_empty=0; alpha_ff_rd_vld=1 in a cycle consumes that head at the
//     next clock edge and is never raised while alpha_ff_empty=1.
//   - BRAM reads are registered: *_dout reflects the address of the previous cycle.
//   - new_feature_bram_ena=1 writes din to addra at the clock edge.
interface aggr_if import aggr_pkg::*; #(
    parameter int TOTAL_NODES   = 13264,
    parameter int NUM_SUBGRAPHS = 2708
) ();
    localparam int WH_ADDR_W       = $clog2(TOTAL_NODES);
    localparam int NUM_NODE_ADDR_W = $clog2(NUM_SUBGRAPHS);
    localparam int NF_ADDR_W       = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);

    logic                         aggr_vld_i;
    logic                         aggr_rdy_o;
    logic [ALPHA_DATA_WIDTH-1:0]  alpha_ff_dout;
    logic                         alpha_ff_empty;
    logic                         alpha_ff_rd_vld;
    logic [NUM_NODE_ADDR_W-1:0]   num_node_bram_addrb;
    logic [NUM_NODE_WIDTH-1:0]    num_node_bram_dout;
    logic [WH_ADDR_W-1:0]         wh_bram_addrb;
    logic [WH_ROW_W-1:0]          wh_bram_dout;
    logic [NF_ADDR_W-1:0]         new_feature_bram_addra;
    logic [NEW_FEATURE_WIDTH-1:0] new_feature_bram_din;
    logic                         new_feature_bram_ena;

    modport slave (
        input  aggr_vld_i, alpha_ff_dout, alpha_ff_empty, num_node_bram_dout, wh_bram_dout,
        output aggr_rdy_o, alpha_ff_rd_vld, num_node_bram_addrb, wh_bram_addrb,
               new_feature_bram_addra, new_feature_bram_din, new_feature_bram_ena
    );

    modport master (
        output aggr_vld_i, alpha_ff_dout, alpha_ff_empty, num_node_bram_dout, wh_bram_dout,
        input  aggr_rdy_o, alpha_ff_rd_vld, num_node_bram_addrb, wh_bram_addrb,
               new_feature_bram_addra, new_feature_bram_din, new_feature_bram_ena
    );
endinterface

// File: rtl/aggr_mac_lane.sv
// aggr_mac_lane: one signed multiply-accumulate lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : zero the accumulator (wins over en)
//   en         : add alpha*wh into the accumulator
//   alpha      : unsigned Q1.31 coefficient
//   wh         : signed WH feature element
//   dout       : accumulator >>> WOF, saturated to NEW_FEATURE_WIDTH
module aggr_mac_lane import aggr_pkg::*; (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                en,
    input  logic        [ALPHA_DATA_WIDTH-1:0]  alpha,
    input  logic signed [WH_DATA_WIDTH-1:0]     wh,
    output logic        [NEW_FEATURE_WIDTH-1:0] dout
);
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    assign prod = PROD_W'($signed({1'b0, alpha})) * PROD_W'(wh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(prod);
    end

    assign dout = saturate(acc);
endmodule

// File: rtl/aggregator.sv
// aggregator: consumer of the softmax alpha FIFO. For each subgraph it pops
// num_node alphas, accumulates alpha * WH row into NUM_FEATURE_OUT lanes and
// writes the resulting feature vector into the new-feature BRAM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : aggr_if.slave (enable, FIFO, num-node/WH BRAM reads, output BRAM write)
//   state      : current FSM state, for observation
module aggregator import aggr_pkg::*; #(
    parameter int TOTAL_NODES   = 13264,
    parameter int NUM_SUBGRAPHS = 2708
) (
    input  logic        clk,
    input  logic        rst_n,
    aggr_if.slave       bus,
    output aggr_state_e state
);
    localparam int WH_ADDR_W       = $clog2(TOTAL_NODES);
    localparam int NUM_NODE_ADDR_W = $clog2(NUM_SUBGRAPHS);
    localparam int NF_ADDR_W       = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);

    aggr_state_e                 state_next;
    logic [NUM_NODE_ADDR_W-1:0]  sg_cnt;
    logic [NUM_NODE_ADDR_W-1:0]  nn_addr;
    logic [NUM_NODE_WIDTH-1:0]   num_node;
    logic [NUM_NODE_WIDTH-1:0]   node_cnt;
    logic [WH_ADDR_W-1:0]        wh_addr;
    logic [ALPHA_DATA_WIDTH-1:0] alpha_reg;
    logic                        acc_en;
    logic [FEAT_IDX_W-1:0]       feat_idx;

    logic pop;
    logic last_pop;
    logic last_feat;
    logic sg_last;
    logic [NEW_FEATURE_WIDTH-1:0] lane_out [NUM_FEATURE_OUT];

    assign pop       = (state == ACCUM) && bus.aggr_vld_i && !bus.alpha_ff_empty;
    assign last_pop  = pop && ((9'(node_cnt) + 9'd1) == 9'(num_node));
    assign last_feat = (state == WRITE) && (feat_idx == FEAT_IDX_W'(NUM_FEATURE_OUT - 1));
    assign sg_last   = (sg_cnt == NUM_NODE_ADDR_W'(NUM_SUBGRAPHS - 1));

    // The WH BRAM is addressed straight from the row pointer; the row for a
    // pop at cycle t arrives at t+1, alongside the registered alpha.
    assign bus.wh_bram_addrb       = wh_addr;
    assign bus.num_node_bram_addrb = nn_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next                 = state;
        bus.alpha_ff_rd_vld        = pop;
        bus.new_feature_bram_ena   = 1'b0;
        bus.new_feature_bram_addra = '0;
        bus.new_feature_bram_din   = '0;
        bus.aggr_rdy_o             = 1'b0;
        case (state)
            IDLE:  if (bus.aggr_vld_i) state_next = FETCH;
            FETCH: state_next = (bus.num_node_bram_dout == '0) ? WRITE : ACCUM;
            ACCUM: if (last_pop) state_next = DRAIN;
            DRAIN: state_next = WRITE;
            WRITE: begin
                bus.new_feature_bram_ena   = 1'b1;
                bus.new_feature_bram_addra = NF_ADDR_W'(sg_cnt) * NF_ADDR_W'(NUM_FEATURE_OUT)
                                           + NF_ADDR_W'(feat_idx);
                bus.new_feature_bram_din   = lane_out[feat_idx];
                bus.aggr_rdy_o             = last_feat;
                if (last_feat) state_next = sg_last ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sg_cnt    <= '0;
            nn_addr   <= '0;
            num_node  <= '0;
            node_cnt  <= '0;
            wh_addr   <= '0;
            alpha_reg <= '0;
            acc_en    <= 1'b0;
            feat_idx  <= '0;
        end else begin
            acc_en <= pop;
            if (state == FETCH) begin
                num_node <= bus.num_node_bram_dout;
                node_cnt <= '0;
            end
            if (pop) begin
                alpha_reg <= bus.alpha_ff_dout;
                wh_addr   <= wh_addr + WH_ADDR_W'(1);
                node_cnt  <= node_cnt + NUM_NODE_WIDTH'(1);
            end
            // The node-count BRAM has a one-cycle read latency and FETCH is a
            // single cycle, so the next subgraph's address is presented as soon
            // as WRITE starts; the count is then stable by the following FETCH.
            if (state_next == WRITE && state != WRITE)
                nn_addr <= sg_last ? '0 : sg_cnt + NUM_NODE_ADDR_W'(1);
            if (state == WRITE)
                feat_idx <= last_feat ? '0 : feat_idx + FEAT_IDX_W'(1);
            if (last_feat) begin
                if (sg_last) begin
                    sg_cnt  <= '0;
                    wh_addr <= '0;
                end else begin
                    sg_cnt  <= sg_cnt + NUM_NODE_ADDR_W'(1);
                end
            end
        end
    end

    for (genvar f = 0; f < NUM_FEATURE_OUT; f++) begin : g_lane
        aggr_mac_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (last_feat),
            .en    (acc_en),
            .alpha (alpha_reg),
            .wh    (bus.wh_bram_dout[f*WH_DATA_WIDTH +: WH_DATA_WIDTH]),
            .dout  (lane_out[f])
        );
    end

    // Bits above the feature elements in a WH row carry nothing for this stage.
    logic unused_wh_hi;
    assign unused_wh_hi = ^bus.wh_bram_dout[WH_ROW_W-1:NUM_FEATURE_OUT*WH_DATA_WIDTH];

endmodule

// File: tb/tb_aggregator.sv
// tb_aggregator: directed bench for aggregator with NUM_SUBGRAPHS=3 and a
// 16-row WH memory. Models the alpha FIFO (FWFT), the registered-read BRAMs,
// and scores every new-feature write against an expected queue.
`timescale 1ns/1ps
module tb_aggregator;
    import aggr_pkg::*;

    localparam int TN  = 16;
    localparam int NSG = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aggr_if #(.TOTAL_NODES(TN), .NUM_SUBGRAPHS(NSG)) bus ();
    aggr_state_e dut_state;

    aggregator #(.TOTAL_NODES(TN), .NUM_SUBGRAPHS(NSG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .state (dut_state)
    );

    // ---------------- memory / FIFO models ----------------
    logic [WH_ROW_W-1:0]       wh_mem [TN];
    logic [NUM_NODE_WIDTH-1:0] nn_mem [4];
    logic [31:0]               alpha_mem [16];
    logic [4:0]                alpha_cnt;
    logic [4:0]                alpha_ptr;
    logic                      fifo_clr;
    logic                      hold_empty;

    assign bus.alpha_ff_dout  = alpha_mem[alpha_ptr[3:0]];
    assign bus.alpha_ff_empty = hold_empty || (alpha_ptr >= alpha_cnt);

    always @(posedge clk) begin
        bus.wh_bram_dout       <= wh_mem[bus.wh_bram_addrb];
        bus.num_node_bram_dout <= nn_mem[bus.num_node_bram_addrb];
        if (fifo_clr)
            alpha_ptr <= '0;
        else if (bus.alpha_ff_rd_vld)
            alpha_ptr <= alpha_ptr + 5'd1;
    end

    // ---------------- scoreboard ----------------
    logic [40:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [40:0] mk(input int addr, input int din, input bit rdy);
        return {rdy, 8'(addr), 32'(din)};
    endfunction

    // kind 0: WH ramp f-8 at alpha 1.0; kind 1: no neighbours; kind 2: 0.5*100 + 0.5*(-50)
    function automatic int exp_val(input int kind, input int f);
        case (kind)
            0:       return f - 8;
            2:       return 25;
            default: return 0;
        endcase
    endfunction

    task automatic push_sg(input int sg, input int kind, input int nf);
        for (int f = 0; f < nf; f++)
            exp_q.push_back(mk(sg*NUM_FEATURE_OUT + f, exp_val(kind, f), f == NUM_FEATURE_OUT-1));
    endtask

    function automatic logic [WH_ROW_W-1:0] row_const(input int v);
        logic [WH_ROW_W-1:0] r;
        r = '1;  // junk in the unused upper bits
        for (int f = 0; f < NUM_FEATURE_OUT; f++)
            r[f*WH_DATA_WIDTH +: WH_DATA_WIDTH] = WH_DATA_WIDTH'(v);
        return r;
    endfunction

    function automatic logic [WH_ROW_W-1:0] row_ramp();
        logic [WH_ROW_W-1:0] r;
        r = '1;
        for (int f = 0; f < NUM_FEATURE_OUT; f++)
            r[f*WH_DATA_WIDTH +: WH_DATA_WIDTH] = WH_DATA_WIDTH'(f - 8);
        return r;
    endfunction

    // ---------------- monitor ----------------
    int cyc = 0;
    int fetch_cyc = 0;
    int lat_q[$];
    int fetch_wh_q[$];
    int illegal_pops = 0;
    int n_writes = 0;
    int n_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.alpha_ff_rd_vld && (bus.alpha_ff_empty || !bus.aggr_vld_i || dut_state != ACCUM))
                illegal_pops++;
            if (bus.aggr_rdy_o && !bus.new_feature_bram_ena)
                illegal_pops++;
            if (dut_state == FETCH) begin
                fetch_cyc = cyc;
                fetch_wh_q.push_back(int'(bus.wh_bram_addrb));
            end
            if (bus.new_feature_bram_ena) begin
                n_writes++;
                if (bus.aggr_rdy_o) begin
                    n_rdy++;
                    lat_q.push_back(cyc - fetch_cyc + 1);
                end
                if (exp_q.size() == 0)
                    check("extra_write", 64'(n_writes), 64'd0);
                else
                    check("write", {bus.aggr_rdy_o, 8'(bus.new_feature_bram_addra),
                                    bus.new_feature_bram_din}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_run1();
        nn_mem[0] = 8'd1; nn_mem[1] = 8'd0; nn_mem[2] = 8'd2; nn_mem[3] = 8'd0;
        wh_mem[0] = row_ramp();
        wh_mem[1] = row_const(100);
        wh_mem[2] = row_const(-50);
        alpha_mem[0] = 32'h8000_0000;
        alpha_mem[1] = 32'h4000_0000;
        alpha_mem[2] = 32'h4000_0000;
        alpha_cnt = 5'd3;
    endtask

    task automatic load_run2();
        nn_mem[0] = 8'd2; nn_mem[1] = 8'd1; nn_mem[2] = 8'd0; nn_mem[3] = 8'd0;
        wh_mem[0] = row_const(100);
        wh_mem[1] = row_const(-50);
        wh_mem[2] = row_ramp();
        alpha_mem[0] = 32'h4000_0000;
        alpha_mem[1] = 32'h4000_0000;
        alpha_mem[2] = 32'h8000_0000;
        alpha_cnt = 5'd3;
    endtask

    task automatic clear_run();
        bus.aggr_vld_i = 1'b0;
        hold_empty = 1'b0;
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        n_writes = 0;
        n_rdy = 0;
        lat_q.delete();
        fetch_wh_q.delete();
    endtask

    // Run all NSG subgraphs; with do_stall, after the first pop hold the FIFO
    // empty for 5 edges, then drop aggr_vld_i for 3 edges.
    task automatic run_pass(input bit do_stall);
        int rdy_seen = 0;
        int phase = 0;
        int cnt = 0;
        int budget = 0;
        bus.aggr_vld_i = 1'b1;
        while (rdy_seen < NSG && budget < 400) begin
            @(negedge clk);
            budget++;
            if (bus.aggr_rdy_o) rdy_seen++;
            if (do_stall) begin
                if (phase == 0) begin
                    if (alpha_ptr == 5'd1 && dut_state == ACCUM) begin
                        hold_empty = 1'b1;
                        phase = 1;
                        cnt = 0;
                    end
                end else if (phase == 1) begin
                    cnt++;
                    if (cnt == 5) begin
                        hold_empty = 1'b0;
                        bus.aggr_vld_i = 1'b0;
                        phase = 2;
                        cnt = 0;
                    end
                end else if (phase == 2) begin
                    cnt++;
                    if (cnt == 3) begin
                        bus.aggr_vld_i = 1'b1;
                        phase = 3;
                    end
                end
            end
        end
        bus.aggr_vld_i = 1'b0;
        if (rdy_seen < NSG) check("run_timeout", 64'(rdy_seen), 64'(NSG));
        @(negedge clk);
        check("back_to_idle", 64'(dut_state), 64'(IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int budget;
        bus.aggr_vld_i = 1'b0;
        hold_empty = 1'b0;
        fifo_clr = 1'b1;
        alpha_cnt = 5'd0;
        for (int i = 0; i < TN; i++) wh_mem[i] = '0;
        for (int i = 0; i < 16; i++) alpha_mem[i] = '0;
        for (int i = 0; i < 4; i++) nn_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(dut_state), 64'(IDLE));
        check("rst_ena", 64'(bus.new_feature_bram_ena), 64'd0);
        check("rst_rd_vld", 64'(bus.alpha_ff_rd_vld), 64'd0);
        check("rst_rdy", 64'(bus.aggr_rdy_o), 64'd0);
        check("rst_wh_addr", 64'(bus.wh_bram_addrb), 64'd0);
        check("rst_nn_addr", 64'(bus.num_node_bram_addrb), 64'd0);
        check("rst_addra", 64'(bus.new_feature_bram_addra), 64'd0);
        check("rst_din", 64'(bus.new_feature_bram_din), 64'd0);
        rst_n = 1'b1;
        clear_run();

        // Run 1: N=1 ramp, N=0 zeros, N=2 mixed rows continuing at WH row 1.
        load_run1();
        push_sg(0, 0, 16);
        push_sg(1, 1, 16);
        push_sg(2, 2, 16);
        run_pass(1'b0);
        check("r1_pending", 64'(exp_q.size()), 64'd0);
        check("r1_writes", 64'(n_writes), 64'd48);
        check("r1_rdy", 64'(n_rdy), 64'd3);
        check("r1_lat_n1", 64'(lat_q[0]), 64'd19);
        check("r1_lat_n2", 64'(lat_q[2]), 64'd20);
        check("r1_wh_fetch0", 64'(fetch_wh_q[0]), 64'd0);
        check("r1_wh_fetch1", 64'(fetch_wh_q[1]), 64'd1);
        check("r1_wh_fetch2", 64'(fetch_wh_q[2]), 64'd1);
        check("r1_pops", 64'(alpha_ptr), 64'd3);
        check("r1_wh_wrap", 64'(bus.wh_bram_addrb), 64'd0);

        // Run 2: stall inside ACCUM of subgraph 0; result unchanged, latency +8.
        clear_run();
        load_run2();
        push_sg(0, 2, 16);
        push_sg(1, 0, 16);
        push_sg(2, 1, 16);
        run_pass(1'b1);
        check("r2_pending", 64'(exp_q.size()), 64'd0);
        check("r2_writes", 64'(n_writes), 64'd48);
        check("r2_lat_stall", 64'(lat_q[0]), 64'd28);
        check("r2_lat_n1", 64'(lat_q[1]), 64'd19);
        check("r2_wh_fetch1", 64'(fetch_wh_q[1]), 64'd2);
        check("r2_wh_fetch2", 64'(fetch_wh_q[2]), 64'd3);
        check("r2_pops", 64'(alpha_ptr), 64'd3);

        // Run 3: reset while writing f=7 of subgraph 0, then restart from scratch.
        clear_run();
        load_run1();
        push_sg(0, 0, 7);
        bus.aggr_vld_i = 1'b1;
        budget = 0;
        while (budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
            if (bus.new_feature_bram_ena && bus.new_feature_bram_addra == 6'd7) break;
        end
        if (budget >= 200) check("r3_timeout", 64'(budget), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("r3_ena", 64'(bus.new_feature_bram_ena), 64'd0);
        check("r3_din", 64'(bus.new_feature_bram_din), 64'd0);
        check("r3_addra", 64'(bus.new_feature_bram_addra), 64'd0);
        check("r3_rdy", 64'(bus.aggr_rdy_o), 64'd0);
        check("r3_rd_vld", 64'(bus.alpha_ff_rd_vld), 64'd0);
        check("r3_state", 64'(dut_state), 64'(IDLE));
        check("r3_wh_addr", 64'(bus.wh_bram_addrb), 64'd0);
        check("r3_abort_pending", 64'(exp_q.size()), 64'd0);
        check("r3_abort_writes", 64'(n_writes), 64'd7);
        clear_run();
        @(negedge clk);
        rst_n = 1'b1;
        push_sg(0, 0, 16);
        push_sg(1, 1, 16);
        push_sg(2, 2, 16);
        run_pass(1'b0);
        check("r3_pending", 64'(exp_q.size()), 64'd0);
        check("r3_writes", 64'(n_writes), 64'd48);
        check("r3_rdy_cnt", 64'(n_rdy), 64'd3);
        check("r3_wh_restart", 64'(fetch_wh_q[0]), 64'd0);

        check("illegal_pops", 64'(illegal_pops), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
